intt2_pipeline_top: RTL and testbench

- Inverse-NTT radix-2 butterfly using the Gentleman-Sande form: xout = (x + y) mod P, yout = ((x − y)·w) mod P.
- Optional in-butterfly scaling by 2⁻¹ mod P, so a full INTT needs no separate n⁻¹ pass.
- Fully pipelined: one butterfly per clock, fixed 6-cycle latency.
- Drop-in partner of the forward NTT butterfly inside the INTT stage controller.

---
 rtl/intt2_pipeline_top_pkg.sv | 20 ++
 rtl/modmul_barrett.sv | 75 +++++++
 rtl/intt2_pipeline_top.sv | 121 ++++++++++++
 tb/tb_intt2_pipeline_top.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/intt2_pipeline_top_pkg.sv
// rtl/intt2_pipeline_top_pkg.sv - shared constants and helpers for the INTT butterfly
package intt2_pipeline_top_pkg;

   // Datapath width and default modulus (2^32 - 5), with its bit length.
   localparam int unsigned     DATAWIDTH = 33;
   localparam logic [32:0]     P_DEFAULT = 33'd4294967291;
   localparam int unsigned     K_DEFAULT = 32;

   // 2^-1 mod P for odd P.
   localparam logic [32:0]     PINV2 = (P_DEFAULT + 33'd1) >> 1;

   // Barrett constant floor(2^(2k) / p); wide enough for any k up to 63.
   function automatic logic [127:0] barrett_mu(input int unsigned k, input logic [127:0] p);
      return (128'd1 << (2 * k)) / p;
   endfunction

   localparam logic [127:0]    MU_FULL = barrett_mu(K_DEFAULT, {95'd0, P_DEFAULT});
   localparam logic [32:0]     MU      = MU_FULL[32:0];

endpackage

// File: rtl/modmul_barrett.sv
// rtl/modmul_barrett.sv - pipelined modular multiplier, Barrett reduction, latency 4
module modmul_barrett
   import intt2_pipeline_top_pkg::*;
#(
   parameter int unsigned     DW = DATAWIDTH,
   parameter logic [DW-1:0]   P  = P_DEFAULT,
   parameter int unsigned     K  = K_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic            in_vld,
   output logic [DW-1:0]   r,
   output logic            out_vld
);

   // Remainder is only needed modulo 2^(K+2), which holds [0, 3P).
   localparam int unsigned       RW      = K + 2;
   localparam logic [127:0]      MU_WIDE = barrett_mu(K, {{(128-DW){1'b0}}, P});
   localparam logic [2*DW:0]     MU_Q    = MU_WIDE[2*DW:0];
   localparam logic [RW-1:0]     P_RW    = {{(RW-DW){1'b0}}, P};
   localparam logic [RW-1:0]     P2_RW   = P_RW << 1;

   logic [2*DW-1:0]  z_q,    z_d;
   logic [2*DW:0]    q2_q,   q2_d;
   logic [RW-1:0]    zlo_q,  zlo_d;
   logic [RW-1:0]    r4_q,   r4_d;
   logic [DW-1:0]    r5_q,   r5_d;
   logic [3:0]       vld_q,  vld_d;
   logic [RW-1:0]    q3;
   logic             unused_q2_low;

   assign unused_q2_low = ^q2_q[K:0];
   assign q3            = q2_q[2*K+2:K+1];

   // Next-state for the multiply, quotient estimate, remainder and correction stages.
   always_comb begin
      z_d   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      q2_d  = {1'b0, (z_q >> (K - 1))} * MU_Q;
      zlo_d = z_q[RW-1:0];
      r4_d  = zlo_q - q3 * P_RW;
      if (r4_q >= P2_RW) begin
         r5_d = r4_q[DW-1:0] - P - P;
      end else if (r4_q >= P_RW) begin
         r5_d = r4_q[DW-1:0] - P;
      end else begin
         r5_d = r4_q[DW-1:0];
      end
      vld_d = {vld_q[2:0], in_vld};
   end

   // Pipeline registers advance every cycle; data is don't-care when its valid bit is 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         z_q   <= '0;
         q2_q  <= '0;
         zlo_q <= '0;
         r4_q  <= '0;
         r5_q  <= '0;
         vld_q <= '0;
      end else begin
         z_q   <= z_d;
         q2_q  <= q2_d;
         zlo_q <= zlo_d;
         r4_q  <= r4_d;
         r5_q  <= r5_d;
         vld_q <= vld_d;
      end
   end

   assign r       = r5_q;
   assign out_vld = vld_q[3];

endmodule

// File: rtl/intt2_pipeline_top.sv
// rtl/intt2_pipeline_top.sv - Gentleman-Sande inverse-NTT butterfly, 6-cycle pipeline
module intt2_pipeline_top
   import intt2_pipeline_top_pkg::*;
#(
   parameter int unsigned     DW = DATAWIDTH,
   parameter logic [DW-1:0]   P  = P_DEFAULT,
   parameter int unsigned     K  = K_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   xin,
   input  logic [DW-1:0]   yin,
   input  logic [DW-1:0]   wr,
   input  logic            half,
   input  logic            en,
   output logic [DW-1:0]   xout,
   output logic [DW-1:0]   yout,
   output logic            valid
);

   localparam logic [DW-1:0] ONE = 1;

   // v * 2^-1 mod P for odd P: odd v gives (v+P)/2 = (v>>1) + (P>>1) + 1, no carry-out.
   function automatic logic [DW-1:0] halve(input logic [DW-1:0] v);
      return v[0] ? (v >> 1) + (P >> 1) + ONE : (v >> 1);
   endfunction

   logic [DW:0]      sum_w;
   logic [DW-1:0]    s1_s_q,    s1_s_d;
   logic [DW-1:0]    s1_d_q,    s1_d_d;
   logic [DW-1:0]    s1_w_q;
   logic             s1_half_q;
   logic             s1_vld_q;
   logic [DW-1:0]    s_dly_q    [4];
   logic [3:0]       half_dly_q;
   logic [DW-1:0]    mm_r;
   logic             mm_vld;
   logic [DW-1:0]    xout_q,    xout_d;
   logic [DW-1:0]    yout_q,    yout_d;
   logic             valid_q;

   // Stage 1 modular add and subtract; results below P fit in DW bits.
   always_comb begin
      sum_w  = {1'b0, xin} + {1'b0, yin};
      s1_s_d = (sum_w >= {1'b0, P}) ? sum_w[DW-1:0] - P : sum_w[DW-1:0];
      s1_d_d = (xin < yin) ? xin - yin + P : xin - yin;
   end

   // Stage 1 registers: sum, difference, twiddle, half flag and valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_s_q    <= '0;
         s1_d_q    <= '0;
         s1_w_q    <= '0;
         s1_half_q <= 1'b0;
         s1_vld_q  <= 1'b0;
      end else begin
         s1_s_q    <= s1_s_d;
         s1_d_q    <= s1_d_d;
         s1_w_q    <= wr;
         s1_half_q <= half;
         s1_vld_q  <= en;
      end
   end

   modmul_barrett #(
      .DW (DW),
      .P  (P),
      .K  (K)
   ) u_modmul (
      .clk     (clk),
      .reset   (reset),
      .a       (s1_d_q),
      .b       (s1_w_q),
      .in_vld  (s1_vld_q),
      .r       (mm_r),
      .out_vld (mm_vld)
   );

   // Delay-match the sum and half flag across the four multiplier stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            s_dly_q[i] <= '0;
         end
         half_dly_q <= '0;
      end else begin
         s_dly_q[0] <= s1_s_q;
         for (int i = 1; i < 4; i++) begin
            s_dly_q[i] <= s_dly_q[i-1];
         end
         half_dly_q <= {half_dly_q[2:0], s1_half_q};
      end
   end

   // Stage 6 optional halving of both results.
   always_comb begin
      xout_d = half_dly_q[3] ? halve(s_dly_q[3]) : s_dly_q[3];
      yout_d = half_dly_q[3] ? halve(mm_r)       : mm_r;
   end

   // Output register loads only on a valid result so outputs hold between results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xout_q  <= '0;
         yout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= mm_vld;
         if (mm_vld) begin
            xout_q <= xout_d;
            yout_q <= yout_d;
         end
      end
   end

   assign xout  = xout_q;
   assign yout  = yout_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_intt2_pipeline_top.sv
// tb/tb_intt2_pipeline_top.sv - randomized self-checking bench for intt2_pipeline_top
module tb_intt2_pipeline_top;
   import intt2_pipeline_top_pkg::*;

   localparam logic [32:0] P = P_DEFAULT;

   typedef struct {
      logic        en;
      logic [32:0] x;
      logic [32:0] y;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [32:0] xin;
   logic [32:0] yin;
   logic [32:0] wr;
   logic        half;
   logic        en;
   logic [32:0] xout;
   logic [32:0] yout;
   logic        valid;

   int          n_checks;
   int          n_fail;
   int          cyc;
   exp_t        exp_q[$];
   logic [32:0] last_x;
   logic [32:0] last_y;

   intt2_pipeline_top dut (
      .clk   (clk),
      .reset (reset),
      .xin   (xin),
      .yin   (yin),
      .wr    (wr),
      .half  (half),
      .en    (en),
      .xout  (xout),
      .yout  (yout),
      .valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [127:0] scale(input logic [127:0] v, input logic h);
      return h ? (v * {95'd0, PINV2}) % {95'd0, P} : v;
   endfunction

   function automatic logic [32:0] ref_x(input logic [32:0] x, input logic [32:0] y, input logic h);
      logic [127:0] t;
      t = ({95'd0, x} + {95'd0, y}) % {95'd0, P};
      t = scale(t, h);
      return t[32:0];
   endfunction

   function automatic logic [32:0] ref_y(input logic [32:0] x, input logic [32:0] y,
                                         input logic [32:0] w, input logic h);
      logic [127:0] t;
      t = ({95'd0, x} + {95'd0, P} - {95'd0, y}) % {95'd0, P};
      t = (t * {95'd0, w}) % {95'd0, P};
      t = scale(t, h);
      return t[32:0];
   endfunction

   function automatic logic [32:0] rnd();
      return {1'b0, $urandom_range(32'd4294967290, 32'd0)};
   endfunction

   function automatic logic [32:0] rnd_edge();
      case ($urandom_range(5, 0))
         0:       return 33'd0;
         1:       return P - 33'd1;
         2:       return 33'd1;
         default: return rnd();
      endcase
   endfunction

   // Queue five idle results so every cycle from now on has an expected output.
   task automatic prefill();
      exp_t rec;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         rec.en = 1'b0;
         rec.x  = '0;
         rec.y  = '0;
         exp_q.push_back(rec);
      end
   endtask

   task automatic step(input logic e, input logic [32:0] x, input logic [32:0] y,
                       input logic [32:0] w, input logic h);
      exp_t rec;
      en   = e;
      xin  = x;
      yin  = y;
      wr   = w;
      half = h;
      rec.en = e;
      rec.x  = ref_x(x, y, h);
      rec.y  = ref_y(x, y, w, h);
      exp_q.push_back(rec);
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() >= 6) begin
         rec = exp_q.pop_front();
         check_eq("valid", {63'd0, valid}, {63'd0, rec.en});
         if (rec.en) begin
            last_x = rec.x;
            last_y = rec.y;
         end
         check_eq("xout", {31'd0, xout}, {31'd0, last_x});
         check_eq("yout", {31'd0, yout}, {31'd0, last_y});
      end
   endtask

   task automatic idle(input int n, input logic noisy);
      for (int i = 0; i < n; i++) begin
         if (noisy) step(1'b0, rnd(), rnd(), rnd(), 1'($urandom_range(1, 0)));
         else       step(1'b0, '0, '0, '0, 1'b0);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      last_x   = '0;
      last_y   = '0;
      reset    = 1'b1;
      en       = 1'b0;
      xin      = '0;
      yin      = '0;
      wr       = '0;
      half     = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_valid", {63'd0, valid}, 64'd0);
      check_eq("reset_xout", {31'd0, xout}, 64'd0);
      check_eq("reset_yout", {31'd0, yout}, 64'd0);
      reset = 1'b0;
      prefill();

      step(1'b1, 33'd5, 33'd3, 33'd2, 1'b0);
      idle(6, 1'b0);

      step(1'b1, 33'd3, 33'd5, 33'd1, 1'b0);
      step(1'b1, P - 33'd1, P - 33'd1, 33'd7, 1'b0);
      step(1'b1, 33'd2, 33'd0, P - 33'd1, 1'b0);
      step(1'b1, 33'd3, 33'd0, 33'd1, 1'b1);
      step(1'b1, 33'd4, 33'd0, 33'd1, 1'b1);
      idle(6, 1'b1);

      for (int i = 0; i < 8; i++) step(1'b1, rnd(), rnd(), rnd(), 1'($urandom_range(1, 0)));
      idle(2, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, rnd(), rnd(), rnd(), 1'($urandom_range(1, 0)));
      idle(6, 1'b1);

      for (int i = 0; i < 300; i++) begin
         step(1'($urandom_range(1, 0)), rnd_edge(), rnd_edge(), rnd_edge(),
              1'($urandom_range(1, 0)));
      end
      idle(6, 1'b1);

      for (int i = 0; i < 9; i++) step(1'b1, rnd(), rnd(), rnd(), 1'($urandom_range(1, 0)));
      check_eq("pre_reset_valid", {63'd0, valid}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_reset_valid", {63'd0, valid}, 64'd0);
      check_eq("async_reset_xout", {31'd0, xout}, 64'd0);
      check_eq("async_reset_yout", {31'd0, yout}, 64'd0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      last_x = '0;
      last_y = '0;
      prefill();
      idle(10, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
